countdown_run_ctrl: RTL and testbench
=====================================

Name: countdown_run_ctrl

Overview:
- Run-time controller for the countdown setter. Captures the six-digit BCD preset, sequences the count toward 00:00:00 at 1 Hz, and handles pause, abort and completion.
- Drives the countdown display word and the alarm request.
- Sits between the countdown setter (source of `set_time`/`go`) and the display mux and buzzer driver.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (100 MHz board clock)
- ALARM_SEC, 10, number of seconds `alarm` stays high after reaching zero
- MODE_ID, 7, value of `mode` for which the countdown page is active

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mode  in  4  current page selector; the run controller responds only to start requests when mode==MODE_ID
- go  in  1  run request level from setter; 0→1 = start, 1→0 = abort
- set_time  in  32  preset {h10,h1,4'hF,m10,m1,4'hF,s10,s1}, BCD
- pause  in  1  single-cycle pulse; toggles run/pause
- clear  in  1  single-cycle pulse; forces return to IDLE
- disp  out  32  live time, same packing as set_time, separators 4'hF
- running  out  1  high in RUN
- done  out  1  high in DONE
- alarm  out  1  high during the first ALARM_SEC seconds of DONE
- sec_tick  out  1  one-cycle pulse on each counted second in RUN

Behaviour:
- Reset values:
  - state=IDLE, prescaler=0, digits=0, go_q=0, alarm_cnt=0.
  - `disp` follows `set_time` combinationally in IDLE.
  - running=0, done=0, alarm=0, sec_tick=0.
- Edge detection: go_q registers `go`. Rise = go & ~go_q. Fall = ~go & go_q.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - `disp` = `set_time`.
  - On rise with mode==MODE_ID, load the digits from `set_time`. Each digit is clamped on load: s10 and m10 >5 → 5; any other digit >9 → 9.
  - On rise, prescaler←0. If the clamped value is all-zero, go to DONE. Otherwise go to RUN.
  - A rise with mode≠MODE_ID is ignored. It is not remembered.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler←0, sec_tick=1 for that cycle, and the BCD value decrements by one second.
  - If the decrement result is 00:00:00, the next state is DONE in the same cycle. `disp` shows 00:00:00.
- BCD decrement (borrow chain):
  - s1 9→0, borrow to s10; s10 5→0, borrow to m1; m1 9→0, borrow to m10; m10 5→0, borrow to h1; h1 9→0, borrow to h10; h10 9→0.
  - A digit at 0 with borrow-in wraps to its maximum.
  - Maximum value is 99:59:59.
- pause pulse:
  - RUN→PAUSE: prescaler frozen, digits frozen.
  - PAUSE→RUN: resume from the frozen prescaler value. There is no restart of the partial second.
  - Ignored in IDLE and DONE.
- DONE:
  - On entry: alarm_cnt←0, alarm=1.
  - Prescaler keeps running. On each tick, alarm_cnt increments. When alarm_cnt reaches ALARM_SEC, alarm←0.
  - Stays in DONE with done=1 until abort.
  - If ALARM_SEC==0, alarm never asserts.
- Abort:
  - Fall or clear in RUN, PAUSE or DONE → IDLE next cycle.
  - All outputs return to their IDLE values, and the digits are not cleared.
  - Fall/clear in IDLE has no effect.
- Simultaneous events, priority: rst > clear > go fall > pause > tick.
  - A tick in the same cycle as an abort is dropped; sec_tick=0 for that cycle.
  - A pause in the same cycle as a tick: the tick is applied first, then the state goes to PAUSE.
- `mode` changes after start do not affect RUN, PAUSE or DONE. The count continues in the background.
- `set_time` changes after load are ignored until the next IDLE.
- Latency:
  - go rise → running=1 one cycle later.
  - Final tick → done=1 and alarm=1 one cycle later.
- rst mid-count: the next cycle is in IDLE, and the count is lost.

Test Plan (TICK_DIV=4, ALARM_SEC=2):
- Basic count:
  - Stimulus: set_time=00:00:03, mode=7, raise go.
  - Required: running=1 next cycle; disp 02, 01, 00 on successive ticks (4 cycles apart); done=1; alarm high for 8 cycles then 0; done stays 1.
- Borrow chain:
  - Stimulus: load 10:00:00.
  - Required: first tick gives disp=09:59:59. Separately, loading 99:59:59 gives 99:59:58.
- Clamp and zero load:
  - Stimulus 1: set_time digits s10=7, m1=A.
  - Required: loads as s10=5, m1=9.
  - Stimulus 2: raise go with 00:00:00.
  - Required: DONE directly, with alarm=1.
- Pause/resume:
  - Stimulus: pause at prescaler=2, hold 20 cycles, pause again.
  - Required: no decrement while paused; next tick 2 cycles after resume.
- Abort and priority:
  - Stimulus 1: drop go on a tick cycle.
  - Required: no decrement, sec_tick=0, IDLE next cycle, disp=set_time.
  - Stimulus 2: clear in DONE.
  - Required: alarm=0 and done=0 next cycle.
- Mode gating and reset:
  - Stimulus 1: go rise with mode=3.
  - Required: stays IDLE.
  - Stimulus 2: rst asserted mid-RUN.
  - Required: IDLE, running=0, alarm=0 next cycle.

Source files
------------

// File: rtl/countdown_run_ctrl.sv
// Countdown run controller: loads a clamped BCD preset, counts it down at one
// tick per TICK_DIV clocks, and manages pause, abort and the end-of-count alarm.
module countdown_run_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int ALARM_SEC = 10,
    parameter int MODE_ID   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mode,
    input  logic        go,
    input  logic [31:0] set_time,
    input  logic        pause,
    input  logic        clear,
    output logic [31:0] disp,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_SEC);
    // Per-digit maximum, ordered {h10,h1,m10,m1,s10,s1}; doubles as the load clamp.
    localparam logic [23:0] DIGIT_MAX = 24'h995959;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t         state;
    logic [PW-1:0]  prescaler;
    logic [23:0]    digits;
    logic           go_q;
    logic [AW-1:0]  alarm_cnt;

    logic           rise;
    logic           abort;
    logic           tick;
    logic [23:0]    loaded;
    logic [23:0]    digits_dec;

    function automatic logic [23:0] clamp_load(input logic [31:0] t);
        logic [23:0] raw;
        logic [23:0] res;
        raw = {t[31:24], t[19:12], t[7:0]};
        res = '0;
        for (int i = 0; i < 6; i++) begin
            res[i*4 +: 4] = (raw[i*4 +: 4] > DIGIT_MAX[i*4 +: 4]) ? DIGIT_MAX[i*4 +: 4]
                                                                 : raw[i*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] d);
        logic [23:0] res;
        logic        borrow;
        res    = d;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (d[i*4 +: 4] == 4'd0) begin
                    res[i*4 +: 4] = DIGIT_MAX[i*4 +: 4];
                end else begin
                    res[i*4 +: 4] = d[i*4 +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign rise       = go & ~go_q;
    assign abort      = clear | (~go & go_q);
    assign tick       = (prescaler == TICK_LAST);
    assign loaded     = clamp_load(set_time);
    assign digits_dec = bcd_dec(digits);
    assign sec_tick   = ~rst & (state == RUN) & tick & ~abort;

    always_comb begin
        disp = set_time;
        if (state != IDLE) begin
            disp = {digits[23:16], 4'hF, digits[15:8], 4'hF, digits[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            digits    <= '0;
            go_q      <= 1'b0;
            alarm_cnt <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            go_q <= go;
            case (state)
                IDLE: begin
                    if (rise && (mode == 4'(MODE_ID))) begin
                        digits    <= loaded;
                        prescaler <= '0;
                        alarm_cnt <= '0;
                        if (loaded == 24'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            alarm <= (ALARM_SEC != 0);
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                // Reaching zero outranks a coincident pause: the count is finished.
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (tick) begin
                        prescaler <= '0;
                        digits    <= digits_dec;
                        if (digits_dec == 24'd0) begin
                            state     <= DONE;
                            running   <= 1'b0;
                            done      <= 1'b1;
                            alarm     <= (ALARM_SEC != 0);
                            alarm_cnt <= '0;
                        end else if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        alarm <= 1'b0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (alarm_cnt != ALARM_MAX) begin
                            alarm_cnt <= alarm_cnt + 1'b1;
                            if (alarm_cnt == ALARM_MAX - 1'b1) begin
                                alarm <= 1'b0;
                            end
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_run_ctrl.sv
// Testbench for countdown_run_ctrl: a fixed vector table, hand-written corner
// sequences, then random stimulus against a seconds-based reference model.
module tb_countdown_run_ctrl;

    localparam int TD  = 4;
    localparam int AS  = 2;
    localparam int MID = 7;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  mode;
    logic        go;
    logic [31:0] set_time;
    logic        pause;
    logic        clear;
    logic [31:0] disp;
    logic        running;
    logic        done;
    logic        alarm;
    logic        sec_tick;

    int checks;
    int errors;

    typedef struct {
        logic        go;
        logic        pause;
        logic        clear;
        logic [3:0]  mode;
        logic [31:0] set_time;
        logic        running;
        logic        done;
        logic        alarm;
        logic        sec_tick;
        logic [31:0] disp;
    } vec_t;

    vec_t vecs[$];

    // Reference model: remaining time kept as an integer number of seconds.
    int m_state;
    int m_secs;
    int m_phase;
    int m_done_ticks;
    bit m_goq;

    countdown_run_ctrl #(.TICK_DIV(TD), .ALARM_SEC(AS), .MODE_ID(MID)) dut (
        .clk(clk), .rst(rst), .mode(mode), .go(go), .set_time(set_time),
        .pause(pause), .clear(clear), .disp(disp), .running(running),
        .done(done), .alarm(alarm), .sec_tick(sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic g, input logic p, input logic c,
                                  input logic [3:0] m, input logic [31:0] st);
        go       = g;
        pause    = p;
        clear    = c;
        mode     = m;
        set_time = st;
    endtask

    // Sample away from the edge, then advance to just after the next rising edge.
    task automatic check_output(input string tag, input logic r, input logic d,
                                input logic a, input logic t, input logic [31:0] dp);
        @(negedge clk);
        check_bit({tag, ".running"}, running, r);
        check_bit({tag, ".done"}, done, d);
        check_bit({tag, ".alarm"}, alarm, a);
        check_bit({tag, ".sec_tick"}, sec_tick, t);
        check_word({tag, ".disp"}, disp, dp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd7, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic void add_vec(input logic g, input logic [31:0] st, input logic r,
                                    input logic d, input logic a, input logic t,
                                    input logic [31:0] dp);
        vec_t v;
        v.go = g; v.pause = 1'b0; v.clear = 1'b0; v.mode = 4'd7; v.set_time = st;
        v.running = r; v.done = d; v.alarm = a; v.sec_tick = t; v.disp = dp;
        vecs.push_back(v);
    endfunction

    function automatic int clamp_secs(input logic [31:0] t);
        int h10, h1, m10, m1, s10, s1;
        h10 = (int'(t[31:28]) > 9) ? 9 : int'(t[31:28]);
        h1  = (int'(t[27:24]) > 9) ? 9 : int'(t[27:24]);
        m10 = (int'(t[19:16]) > 5) ? 5 : int'(t[19:16]);
        m1  = (int'(t[15:12]) > 9) ? 9 : int'(t[15:12]);
        s10 = (int'(t[7:4])   > 5) ? 5 : int'(t[7:4]);
        s1  = (int'(t[3:0])   > 9) ? 9 : int'(t[3:0]);
        return (h10 * 10 + h1) * 3600 + (m10 * 10 + m1) * 60 + s10 * 10 + s1;
    endfunction

    function automatic logic [31:0] pack_secs(input int s);
        int h, m, sec;
        h   = s / 3600;
        m   = (s % 3600) / 60;
        sec = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'hF, 4'(m / 10), 4'(m % 10), 4'hF,
                4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic void model_reset();
        m_state = S_IDLE; m_secs = 0; m_phase = 0; m_done_ticks = 0; m_goq = 1'b0;
    endfunction

    function automatic void model_step();
        bit rise, fall, tk;
        rise = go && !m_goq;
        fall = !go && m_goq;
        tk   = (m_phase == TD - 1);
        if (rst) begin
            model_reset();
            return;
        end
        m_goq = go;
        case (m_state)
            S_IDLE: if (rise && mode == 4'(MID)) begin
                m_secs = clamp_secs(set_time);
                m_phase = 0;
                m_done_ticks = 0;
                m_state = (m_secs == 0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (clear || fall) m_state = S_IDLE;
                else begin
                    m_phase = tk ? 0 : m_phase + 1;
                    if (tk) m_secs = m_secs - 1;
                    if (tk && m_secs == 0) begin
                        m_state = S_DONE;
                        m_done_ticks = 0;
                    end else if (pause) m_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (clear || fall) m_state = S_IDLE;
                else if (pause) m_state = S_RUN;
            end
            default: begin
                if (clear || fall) m_state = S_IDLE;
                else begin
                    m_phase = tk ? 0 : m_phase + 1;
                    if (tk && m_done_ticks < AS) m_done_ticks++;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_time();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return {8'h00, 4'hF, 4'h0, 4'(($urandom_range(0, 3) == 0) ? 1 : 0), 4'hF,
                4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd7, 32'h0);

        // Vector table: basic 3-second count, alarm window, abort by go fall.
        add_vec(1'b0, 32'h00F00F03, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F03);
        add_vec(1'b1, 32'h00F00F03, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F03);
        for (int k = 3; k >= 1; k--) begin
            for (int ph = 0; ph < TD; ph++) begin
                add_vec(1'b1, 32'h00F00F03, 1'b1, 1'b0, 1'b0, (ph == TD - 1),
                        32'h00F00F00 | 32'(k));
            end
        end
        for (int i = 0; i < 2 * TD; i++)
            add_vec(1'b1, 32'h00F00F03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00F00F00);
        add_vec(1'b1, 32'h00F00F03, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00F00F00);
        add_vec(1'b1, 32'h00F00F03, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00F00F00);
        add_vec(1'b0, 32'h00F00F03, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00F00F00);
        add_vec(1'b0, 32'h00F00F03, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F03);
        add_vec(1'b0, 32'h12F34F56, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12F34F56);

        do_reset();
        check_output("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].go, vecs[i].pause, vecs[i].clear, vecs[i].mode,
                           vecs[i].set_time);
            check_output($sformatf("vec%0d", i), vecs[i].running, vecs[i].done,
                         vecs[i].alarm, vecs[i].sec_tick, vecs[i].disp);
        end

        // Borrow chain through every digit, then the maximum value.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h10F00F00);
        check_output("borrow_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h10F00F00);
        repeat (TD - 1) check_output("borrow_run", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10F00F00);
        check_output("borrow_tick", 1'b1, 1'b0, 1'b0, 1'b1, 32'h10F00F00);
        check_output("borrow_result", 1'b1, 1'b0, 1'b0, 1'b0, 32'h09F59F59);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd7, 32'h99F59F59);
        check_output("borrow_abort", 1'b1, 1'b0, 1'b0, 1'b0, 32'h09F59F59);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h99F59F59);
        check_output("max_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h99F59F59);
        repeat (TD - 1) check_output("max_run", 1'b1, 1'b0, 1'b0, 1'b0, 32'h99F59F59);
        check_output("max_tick", 1'b1, 1'b0, 1'b0, 1'b1, 32'h99F59F59);
        check_output("max_result", 1'b1, 1'b0, 1'b0, 1'b0, 32'h99F59F58);

        // Clamp on load: s10=7 -> 5, m1=A -> 9.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F0AF72);
        check_output("clamp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F0AF72);
        check_output("clamp_load", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F09F52);

        // Zero preset goes straight to DONE; clear there returns to IDLE.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F00);
        check_output("zero_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F00);
        check_output("zero_done", 1'b0, 1'b1, 1'b1, 1'b0, 32'h00F00F00);
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'd7, 32'h00F00F00);
        check_output("clear_in_done", 1'b0, 1'b1, 1'b1, 1'b0, 32'h00F00F00);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F00);
        check_output("after_clear", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F00);

        // Pause with the prescaler frozen at 2, hold 20 cycles, resume.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("pause_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        check_output("pause_ph0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd7, 32'h00F00F05);
        check_output("pause_req", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        repeat (20) check_output("paused", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd7, 32'h00F00F05);
        check_output("resume_req", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("resume_ph2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        check_output("resume_tick", 1'b1, 1'b0, 1'b0, 1'b1, 32'h00F00F05);
        check_output("resume_dec", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F04);

        // go falls on a tick cycle: tick dropped, IDLE next cycle.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("abort_idle0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        repeat (TD - 1) check_output("abort_run", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("abort_tick", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd7, 32'h00F00F07);
        check_output("abort_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F07);

        // Rise with the wrong page is ignored and not remembered.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd3, 32'h00F00F05);
        check_output("mode_rise", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        check_output("mode_gated", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("mode_switch", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        check_output("mode_not_kept", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);

        // Synchronous reset in the middle of a count.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        check_output("rst_run", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd7, 32'h00F00F05);
        check_output("rst_cycle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00F00F05);
        rst = 1'b0;
        check_output("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h00F00F05);

        // Random stimulus against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 79) == 0) go = ~go;
            pause = ($urandom_range(0, 14) == 0);
            clear = ($urandom_range(0, 149) == 0);
            mode  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd7;
            if ($urandom_range(0, 19) == 0) set_time = rand_time();
            @(negedge clk);
            check_bit("rand.running", running, m_state == S_RUN);
            check_bit("rand.done", done, m_state == S_DONE);
            check_bit("rand.alarm", alarm, (m_state == S_DONE) && (m_done_ticks < AS));
            check_bit("rand.sec_tick", sec_tick,
                      !rst && (m_state == S_RUN) && (m_phase == TD - 1) && !clear &&
                      !(!go && m_goq));
            check_word("rand.disp", disp, (m_state == S_IDLE) ? set_time : pack_secs(m_secs));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
